// File: rtl/vape_dma_master.sv
// vape_dma_master
//   Bus-master DMA engine. Copies cfg_len 16-bit words from cfg_src to cfg_dst
//   over an openMSP430-style DMA port. Each word is one read handshake, one
//   capture cycle and one write handshake.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   cfg_src/dst/len       transfer setup, latched on an accepted start
//   start, abort          one-cycle request / stop at next handshake boundary
//   busy, done, err       status (done is a one-cycle pulse, err is sticky)
//   words_left            remaining word count
//   dma_addr/en/we/din    registered bus request
//   dma_dout/ready/resp   bus read data, accept, error response
module vape_dma_master #(
  parameter logic [15:0] MAX_LEN = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cfg_src,
  input  logic [15:0] cfg_dst,
  input  logic [15:0] cfg_len,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_left,
  output logic [15:0] dma_addr,
  output logic        dma_en,
  output logic [1:0]  dma_we,
  output logic [15:0] dma_din,
  input  logic [15:0] dma_dout,
  input  logic        dma_ready,
  input  logic        dma_resp
);

  typedef enum logic [1:0] {IDLE, RD, RDATA, WR} state_e;

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d, din_q, din_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        en_q, en_d, stop_q, stop_d;
  logic [1:0]  we_q, we_d;
  logic        acc, fin;
  logic [16:0] len_diff;
  logic [15:0] len_clamp;

  assign acc = en_q & dma_ready;

  // Borrow out of MAX_LEN - cfg_len means cfg_len exceeds the limit.
  assign len_diff  = {1'b0, MAX_LEN} - {1'b0, cfg_len};
  assign len_clamp = len_diff[16] ? MAX_LEN : cfg_len;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    en_d    = en_q;
    we_d    = we_q;
    stop_d  = stop_q;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_len != 16'd0) begin
            src_d   = cfg_src & 16'hFFFE;
            dst_d   = cfg_dst & 16'hFFFE;
            cnt_d   = len_clamp;
            err_d   = 1'b0;
            stop_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = RD;
            en_d    = 1'b1;
            we_d    = 2'b00;
            addr_d  = cfg_src & 16'hFFFE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD: begin
        if (acc) begin
          state_d = RDATA;
          en_d    = 1'b0;
          // Abort coinciding with read accept: finish this word, then stop.
          stop_d  = abort;
        end else if (abort) begin
          fin = 1'b1;
        end
      end
      RDATA: begin
        din_d = dma_dout;
        if (dma_resp) begin
          err_d = 1'b1;
          fin   = 1'b1;
        end else if (abort) begin
          fin = 1'b1;
        end else begin
          state_d = WR;
          en_d    = 1'b1;
          we_d    = 2'b11;
          addr_d  = dst_q;
        end
      end
      WR: begin
        if (acc) begin
          src_d = src_q + 16'd2;
          dst_d = dst_q + 16'd2;
          cnt_d = cnt_q - 16'd1;
          if (dma_resp) begin
            err_d = 1'b1;
            fin   = 1'b1;
          end else if ((cnt_d == 16'd0) || abort || stop_q) begin
            fin = 1'b1;
          end else begin
            state_d = RD;
            we_d    = 2'b00;
            addr_d  = src_d;
          end
        end else if (abort) begin
          fin = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      en_d    = 1'b0;
      we_d    = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= 16'd0;
      dst_q   <= 16'd0;
      cnt_q   <= 16'd0;
      addr_q  <= 16'd0;
      din_q   <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 2'b00;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      we_q    <= we_d;
      stop_q  <= stop_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign words_left = cnt_q;
  assign dma_addr   = addr_q;
  assign dma_en     = en_q;
  assign dma_we     = we_q;
  assign dma_din    = din_q;

endmodule

// File: tb/tb_vape_dma_master.sv
// Scoreboard bench for vape_dma_master: stimulus pushes the expected bus
// transactions and done status; a negedge monitor acts as bus slave and pops
// and compares whenever a handshake is accepted or done pulses.
module tb_vape_dma_master;
  localparam logic [15:0] MAXL = 16'd20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cfg_src = 16'd0, cfg_dst = 16'd0, cfg_len = 16'd0;
  logic        start = 1'b0, abort = 1'b0;
  logic        busy, done, err;
  logic [15:0] words_left, dma_addr, dma_din;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic [15:0] dma_dout = 16'd0;
  logic        dma_ready = 1'b0, dma_resp = 1'b0;

  always #5 clk = ~clk;

  vape_dma_master #(.MAX_LEN(MAXL)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_src(cfg_src), .cfg_dst(cfg_dst),
    .cfg_len(cfg_len), .start(start), .abort(abort), .busy(busy), .done(done),
    .err(err), .words_left(words_left), .dma_addr(dma_addr), .dma_en(dma_en),
    .dma_we(dma_we), .dma_din(dma_din), .dma_dout(dma_dout),
    .dma_ready(dma_ready), .dma_resp(dma_resp)
  );

  typedef struct { logic we; logic [15:0] addr; logic [15:0] data; } bus_t;
  typedef struct { logic err; logic [15:0] wl; } done_t;

  bus_t        exp_q[$];
  done_t       done_q[$];
  logic [15:0] mem [32768];
  int          pass_cnt = 0, tot_cnt = 0;
  logic        m_err = 1'b0;
  logic [15:0] m_wl = 16'd0;
  // 0: always ready, 1: 4 wait cycles, 2: random 0..3, 3: never, 4: writes never
  int          stall_mode = 0;
  int          rd_err_idx = -1;
  int          rd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Bus slave + scoreboard monitor.
  initial begin
    logic        pend, rd_acc, snap_v;
    int          wait_cnt, cur_stall, rd_idx;
    logic [15:0] rd_addr;
    logic [34:0] snap;
    bus_t        e;
    done_t       d;
    pend = 0; rd_acc = 0; snap_v = 0; wait_cnt = 0; cur_stall = 0; rd_idx = 0;
    rd_addr = 0; snap = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 0; rd_acc = 0; snap_v = 0; dma_ready = 0; dma_resp = 0;
      end else begin
        // A stalled request must be held unchanged unless an abort ended it.
        if (snap_v && !done) check("stall_hold", 32'({dma_en, dma_we, dma_addr, dma_din}), 32'(snap));
        snap_v = 0;
        if (rd_acc) begin
          dma_dout = mem[rd_addr[15:1]];
          dma_resp = (rd_idx == rd_err_idx);
        end else begin
          dma_dout = 16'($urandom);
          dma_resp = 1'b0;
        end
        rd_acc = 0;
        if (dma_en) begin
          if (!pend) begin
            pend = 1; wait_cnt = 0;
            cur_stall = (stall_mode == 1) ? 4 : (stall_mode == 2) ? int'($urandom_range(0, 3)) : 0;
          end
          if (stall_mode == 3 || (stall_mode == 4 && dma_we == 2'b11)) dma_ready = 1'b0;
          else dma_ready = (wait_cnt >= cur_stall);
          wait_cnt++;
          if (dma_ready) begin
            pend = 0;
            if (exp_q.size() == 0) begin
              tot_cnt++;
              $display("FAIL unexpected_bus: got we=%0h addr=%0h expected no transfer", dma_we, dma_addr);
            end else begin
              e = exp_q.pop_front();
              check("bus_we", 32'(dma_we), 32'({2{e.we}}));
              check("bus_addr", 32'(dma_addr), 32'(e.addr));
              if (e.we) check("bus_wdata", 32'(dma_din), 32'(e.data));
            end
            if (dma_we == 2'b00) begin
              rd_acc = 1; rd_addr = dma_addr; rd_idx = rd_cnt; rd_cnt++;
            end
          end else begin
            snap_v = 1;
            snap = {dma_en, dma_we, dma_addr, dma_din};
          end
        end else begin
          pend = 0;
          dma_ready = 1'($urandom_range(0, 1));
        end
        if (done) begin
          if (done_q.size() == 0) begin
            tot_cnt++;
            $display("FAIL unexpected_done: got done=1 expected 0");
          end else begin
            d = done_q.pop_front();
            check("done_err", 32'(err), 32'(d.err));
            check("done_words_left", 32'(words_left), 32'(d.wl));
            check("done_busy", 32'(busy), 32'(0));
            check("done_en", 32'(dma_en), 32'(0));
          end
        end
      end
    end
  end

  // Reference model of one transfer, then drive start and wait for done.
  task automatic issue(input logic [15:0] src, input logic [15:0] dst,
                       input logic [15:0] len, input int err_at, output int cyc);
    int          n;
    logic [15:0] s, d;
    n = int'((len > MAXL) ? MAXL : len);
    s = src & 16'hFFFE;
    d = dst & 16'hFFFE;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b0, s, 16'h0});
      if (i == err_at) break;
      exp_q.push_back('{1'b1, d, mem[s[15:1]]});
      s = s + 16'd2;
      d = d + 16'd2;
    end
    if (n > 0) begin
      m_err = (err_at >= 0 && err_at < n);
      m_wl  = m_err ? 16'(n - err_at) : 16'd0;
    end
    done_q.push_back('{m_err, m_wl});
    rd_err_idx = err_at;
    rd_cnt = 0;
    cfg_src = src; cfg_dst = dst; cfg_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      tot_cnt++;
      $display("FAIL done_timeout: got no done expected done within 3000 cycles");
    end
    check("leftover_bus", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_err"}, 32'(err), 32'(0));
    check({tag, "_words_left"}, 32'(words_left), 32'(0));
    check({tag, "_en"}, 32'(dma_en), 32'(0));
    check({tag, "_we"}, 32'(dma_we), 32'(0));
    check({tag, "_addr"}, 32'(dma_addr), 32'(0));
    check({tag, "_din"}, 32'(dma_din), 32'(0));
  endtask

  initial begin
    int          cyc, k, len, ea;
    logic [15:0] a, b;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic copy, zero wait: 3 words at 3 cycles each, done 10 after start.
    stall_mode = 0;
    issue(16'h0200, 16'h0400, 16'd3, -1, cyc);
    check("basic_latency", 32'(cyc), 32'(10));

    // Four wait states on every request.
    stall_mode = 1;
    issue(16'h1234, 16'h4320, 16'd3, -1, cyc);

    // Odd source, wraps through 16'hFFFE -> 16'h0000.
    stall_mode = 2;
    issue(16'hFFFF, 16'h3001, 16'd2, -1, cyc);

    // Zero length: done one cycle after start, no bus traffic.
    stall_mode = 0;
    issue(16'h0100, 16'h0200, 16'd0, -1, cyc);
    check("zero_latency", 32'(cyc), 32'(1));

    // Error on the second read; the next start clears err.
    issue(16'h1000, 16'h2000, 16'd4, 1, cyc);
    check("rderr_err", 32'(err), 32'(1));
    issue(16'h1100, 16'h2100, 16'd2, -1, cyc);
    check("rderr_cleared", 32'(err), 32'(0));

    // Length above MAX_LEN is clamped.
    stall_mode = 2;
    issue(16'h5000, 16'h6000, 16'd100, -1, cyc);

    // Randomized transfers.
    for (int t = 0; t < 20; t++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      len = int'($urandom_range(0, 8));
      ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      issue(a, b, 16'(len), ea, cyc);
      @(negedge clk);
    end

    // Abort during a stalled write: only the read completes.
    stall_mode = 4;
    m_err = 1'b0; m_wl = 16'd3;
    exp_q.push_back('{1'b0, 16'h0800, 16'h0});
    done_q.push_back('{1'b0, 16'd3});
    rd_err_idx = -1; rd_cnt = 0;
    cfg_src = 16'h0800; cfg_dst = 16'h0900; cfg_len = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(dma_en && dma_we == 2'b11) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      tot_cnt++;
      $display("FAIL abort_wr_wait: got no write request expected one within 50 cycles");
    end
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_en_drop", 32'(dma_en), 32'(0));
    check("abort_done", 32'(done), 32'(1));
    check("abort_leftover", 32'(exp_q.size()), 32'(0));
    repeat (2) @(negedge clk);

    // Reset in the middle of a stalled read.
    stall_mode = 3;
    cfg_src = 16'h0A00; cfg_dst = 16'h0B00; cfg_len = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rd_pending", 32'(dma_en), 32'(1));
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'(0));
    end
    reset_n = 1'b1;
    m_err = 1'b0; m_wl = 16'd0;
    repeat (2) @(negedge clk);
    check("post_rst_no_done", 32'(done), 32'(0));

    // Recovery after reset.
    stall_mode = 0;
    issue(16'h0C00, 16'h0D00, 16'd2, -1, cyc);
    check("recover_latency", 32'(cyc), 32'(7));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
